// File: rtl/mem_arbiter.sv
// Two-master (fetch / data) arbiter in front of a single-port, one-cycle-latency memory.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise the data port has fixed priority.
module mem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_valid,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err_spurious
);
    typedef struct packed {
        logic                  wen;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    logic                  gnt_i, gnt_d;
    logic                  inflight, owner;
    logic                  route_i, route_d;
    logic [DATA_WIDTH-1:0] i_hold, d_hold;
    req_t                  req;

`ifdef MEM_ARB_RR_EN
    // last_win: 0 = fetch won the most recent contended grant, 1 = data did
    logic last_win;

    assign gnt_d = ~rst & d_valid & ~(i_valid & last_win);
    assign gnt_i = ~rst & i_valid & ~(d_valid & ~last_win);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_win <= 1'b0;
        else if (i_valid & d_valid)
            last_win <= gnt_d;
    end
`else
    assign gnt_d = ~rst & d_valid;
    assign gnt_i = ~rst & i_valid & ~d_valid;
`endif

    always_comb begin
        req = '0;
        if (gnt_d) begin
            req.wen   = d_wen;
            req.addr  = d_addr;
            req.wdata = d_wdata;
        end else if (gnt_i) begin
            req.addr  = i_addr;
        end
    end

    assign i_ready   = gnt_i;
    assign d_ready   = gnt_d;
    assign mem_valid = gnt_i | gnt_d;
    assign mem_wen   = req.wen;
    assign mem_addr  = req.addr;
    assign mem_wdata = req.wdata;

    // Responses pass straight through on the routed cycle and are held afterwards.
    assign route_i  = mem_rvalid & inflight & ~owner;
    assign route_d  = mem_rvalid & inflight & owner;
    assign i_rvalid = route_i;
    assign d_rvalid = route_d;
    assign i_rdata  = route_i ? mem_rdata : i_hold;
    assign d_rdata  = route_d ? mem_rdata : d_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight     <= 1'b0;
            owner        <= 1'b0;
            i_hold       <= '0;
            d_hold       <= '0;
            err_spurious <= 1'b0;
        end else begin
            inflight <= mem_valid;
            owner    <= gnt_d;
            if (route_i)
                i_hold <= mem_rdata;
            if (route_d)
                d_hold <= mem_rdata;
            if (mem_rvalid & ~inflight)
                err_spurious <= 1'b1;
        end
    end
endmodule
